dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single-port DataMemory between the pipeline's DM stage (CPU requester) and an external loader/debug port (loader requester).
- The CPU wins by default. A starvation counter guarantees the loader a slot after MAX_STARVE denied cycles.
- The loader uses a req/ack handshake.
- The arbiter stalls the pipeline whenever the CPU is denied.

Parameters:
- ADDR_W, 8, address width of DataMemory.
- DATA_W, 8, data width.
- MAX_STARVE, 4, consecutive denied loader cycles before the loader is forced ahead of the CPU. 0 = loader strict priority. Range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  DM stage needs memory this cycle (load or store).
- cpu_we  input  1  CPU access is a write.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_rdata  output  DATA_W  CPU read data (combinational).
- cpu_stall  output  1  CPU denied this cycle; the pipeline must hold.
- ld_req  input  1  loader request; held with stable fields until ld_ack.
- ld_we  input  1  loader access is a write.
- ld_addr  input  ADDR_W  loader address.
- ld_wdata  input  DATA_W  loader write data.
- ld_ack  output  1  one-cycle pulse: loader access completed.
- ld_rdata  output  DATA_W  registered loader read data; valid while ld_ack=1.
- mem_addr  output  ADDR_W  DataMemory address.
- mem_we  output  1  DataMemory write enable.
- mem_din  output  DATA_W  DataMemory write data.
- mem_dout  input  DATA_W  DataMemory read data (combinational read).

Behaviour:
- State register: IDLE, ACK. Starvation counter starve_cnt is 4 bits.
- Reset values: state=IDLE, starve_cnt=0, ld_ack=0, ld_rdata=0. Combinational outputs settle to 0 with no requests.
- ld_elig = ld_req AND state==IDLE. While in ACK the loader is ineligible, which prevents a duplicate access on a held request.
- Grant, decided combinationally each cycle:
  - Loader wins if ld_elig AND (NOT cpu_req OR starve_cnt >= MAX_STARVE).
  - Else the CPU wins if cpu_req.
  - Else no grant.
- Memory drive:
  - Winner's addr/we/wdata go to mem_*.
  - No grant: mem_we=0, mem_addr=0, mem_din=0.
- cpu_rdata = mem_dout when the CPU is granted, else 0.
- cpu_stall = cpu_req AND loader granted. Zero-latency and combinational; the DM stage holds its instruction until cpu_stall=0.
- State transitions:
  - IDLE -> ACK on any loader grant. On that edge: ld_rdata <= mem_dout (ld_we=0), or ld_rdata <= 0 for writes.
  - ACK -> IDLE unconditionally after one cycle. ld_ack=1 exactly while state==ACK.
  - Loader latency: grant cycle + 1 cycle ack, i.e. a minimum of 2 cycles per loader access.
- starve_cnt update, evaluated in order:
  1. Cleared on a loader grant or when ld_elig=0.
  2. Incremented (saturating at 15) when ld_elig=1 and the loader is denied.
- Boundary conditions:
  - Both request with starve_cnt < MAX_STARVE: CPU wins, no stall, counter increments.
  - MAX_STARVE=0: loader always beats the CPU when eligible.
  - Loader drops ld_req before ack: illegal; behaviour undefined. The bench must not do this.
  - CPU and loader writing the same address in one cycle is impossible, since only one is granted.
  - Reset asserted in ACK: ack pulse aborted, ld_ack=0 immediately. The loader treats the access as done only if ack was seen; it must otherwise re-request after reset.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds output stall_cycles (16 bits). It counts cycles with cpu_stall=1 and saturates at 16'hFFFF.
  - Adds output ld_grants (16 bits). It counts loader grants and saturates.
  - Both reset to 0 on rst.
- Undefined: neither port nor its counters exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset release, no requests -> mem_we=0, mem_addr=0, cpu_stall=0, ld_ack=0, ld_rdata=0.
- CPU only: cpu_req=1, cpu_we=1, addr=8'h10, wdata=8'hA5, then a read of 8'h10 -> mem_we pulses once, cpu_rdata=8'hA5, cpu_stall=0 throughout.
- Loader only: ld_req write 8'h3C to 8'h20, then a read of 8'h20 -> each access gives ld_ack high exactly one cycle after grant; the second ack carries ld_rdata=8'h3C; 2 cycles per access.
- Contention, MAX_STARVE=4, cpu_req and ld_req held high -> CPU granted cycles 0-3, loader granted cycle 4 with cpu_stall=1 only in cycle 4, ack cycle 5, CPU granted cycle 5.
- Held ld_req across ACK -> exactly one memory access per request (no double write observed at mem_we).
- Reset asserted during the ACK cycle -> ld_ack drops immediately, starve_cnt=0. With DM_ARB_STATS_EN: stall_cycles=0 and ld_grants=0 after reset, and stall_cycles=1 after the contention scenario.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// DataMemory port arbiter: CPU DM stage vs. loader, with starvation guard.
// Define DM_ARB_STATS_EN to add stall_cycles / ld_grants counters.
module dm_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       ld_grants
`endif
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       ld_elig;
  logic       ld_gnt;
  logic       cpu_gnt;

  // Loader is blocked in ACK so a held request is not serviced twice.
  assign ld_elig = ld_req && (state == IDLE);
  assign ld_gnt  = ld_elig && (!cpu_req || (starve_cnt >= STARVE_LIM));
  assign cpu_gnt = cpu_req && !ld_gnt;

  assign cpu_stall = cpu_req && ld_gnt;
  assign ld_ack    = (state == ACK);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_din   = '0;
    cpu_rdata = '0;
    unique case (1'b1)
      ld_gnt: begin
        mem_addr = ld_addr;
        mem_we   = ld_we;
        mem_din  = ld_wdata;
      end
      cpu_gnt: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_din   = cpu_wdata;
        cpu_rdata = mem_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ld_rdata <= '0;
    end else if (ld_gnt) begin
      state    <= ACK;
      ld_rdata <= ld_we ? '0 : mem_dout;
    end else if (state == ACK) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (ld_gnt || !ld_elig)
      starve_cnt <= '0;
    else if (starve_cnt != 4'hF)
      starve_cnt <= starve_cnt + 4'd1;
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      ld_grants    <= '0;
    end else begin
      if (cpu_stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (ld_gnt && ld_grants != 16'hFFFF)
        ld_grants <= ld_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural DataMemory.
// Includes a MAX_STARVE=0 instance for the strict-priority case.
module tb_dm_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       ld_req, ld_we;
  logic [7:0] ld_addr, ld_wdata;
  logic       ld_ack;
  logic [7:0] ld_rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  logic [7:0] z_rdata, z_ld_rdata, z_addr, z_din;
  logic       z_stall, z_ack, z_we;
  logic [7:0] z_dout = 8'h00;

`ifdef DM_ARB_STATS_EN
  logic [15:0] stall_cycles, ld_grants;
  logic [15:0] z_stall_cycles, z_ld_grants;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      wr_cnt++;
    end
  end

  dm_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_STARVE(4)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef DM_ARB_STATS_EN
    , .stall_cycles(stall_cycles), .ld_grants(ld_grants)
`endif
  );

  dm_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_STARVE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(z_rdata), .cpu_stall(z_stall),
    .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(z_ack), .ld_rdata(z_ld_rdata),
    .mem_addr(z_addr), .mem_we(z_we),
    .mem_din(z_din), .mem_dout(z_dout)
`ifdef DM_ARB_STATS_EN
    , .stall_cycles(z_stall_cycles), .ld_grants(z_ld_grants)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int w0;

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_ld_rdata", ld_rdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
`ifdef DM_ARB_STATS_EN
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_ld_grants", ld_grants, 0);
`endif

    // CPU write then read of 0x10
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    #1;
    chk("cpu_wr_we", mem_we, 1);
    chk("cpu_wr_addr", mem_addr, 8'h10);
    chk("cpu_wr_din", mem_din, 8'hA5);
    chk("cpu_wr_stall", cpu_stall, 0);
    tick();
    cpu_we = 0;
    #1;
    chk("cpu_rd_we", mem_we, 0);
    chk("cpu_rd_data", cpu_rdata, 8'hA5);
    chk("cpu_rd_stall", cpu_stall, 0);
    chk("cpu_wr_count", wr_cnt, 1);
    tick();
    cpu_req = 0;

    // Loader write 0x3C to 0x20
    tick();
    ld_req = 1; ld_we = 1; ld_addr = 8'h20; ld_wdata = 8'h3C;
    #1;
    chk("ld_wr_we", mem_we, 1);
    chk("ld_wr_addr", mem_addr, 8'h20);
    chk("ld_wr_din", mem_din, 8'h3C);
    chk("ld_wr_noack", ld_ack, 0);
    tick();
    chk("ld_wr_ack", ld_ack, 1);
    chk("ld_wr_ack_we", mem_we, 0);
    chk("ld_wr_ack_addr", mem_addr, 0);
    chk("ld_wr_rdata", ld_rdata, 0);
    ld_req = 0;
    tick();
    chk("ld_wr_ack_end", ld_ack, 0);
    chk("ld_wr_count", wr_cnt, 2);

    // Loader read of 0x20
    ld_req = 1; ld_we = 0; ld_addr = 8'h20;
    #1;
    chk("ld_rd_addr", mem_addr, 8'h20);
    chk("ld_rd_we", mem_we, 0);
    tick();
    chk("ld_rd_ack", ld_ack, 1);
    chk("ld_rd_data", ld_rdata, 8'h3C);
    ld_req = 0;
    tick();
    chk("ld_rd_ack_end", ld_ack, 0);

    // Contention, MAX_STARVE=4
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    ld_req = 1; ld_we = 0; ld_addr = 8'h20;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("cont_c%0d_stall", c), cpu_stall, 0);
      chk($sformatf("cont_c%0d_addr", c), mem_addr, 8'h10);
      chk($sformatf("cont_c%0d_rdata", c), cpu_rdata, 8'hA5);
      tick();
    end
    chk("cont_c4_stall", cpu_stall, 1);
    chk("cont_c4_addr", mem_addr, 8'h20);
    chk("cont_c4_rdata", cpu_rdata, 0);
    tick();
    chk("cont_c5_ack", ld_ack, 1);
    chk("cont_c5_ldrdata", ld_rdata, 8'h3C);
    chk("cont_c5_stall", cpu_stall, 0);
    chk("cont_c5_addr", mem_addr, 8'h10);
    ld_req = 0; cpu_req = 0;
    tick();

    // Held request across ACK: exactly one write
    w0 = wr_cnt;
    ld_req = 1; ld_we = 1; ld_addr = 8'h30; ld_wdata = 8'h77;
    tick();
    chk("held_ack", ld_ack, 1);
    chk("held_ack_we", mem_we, 0);
    ld_req = 0;
    tick();
    chk("held_wr_count", wr_cnt, w0 + 1);
    chk("held_mem", mem[8'h30], 8'h77);

    // Reset during ACK
    ld_req = 1; ld_we = 0; ld_addr = 8'h30;
    tick();
    chk("rstack_pre", ld_ack, 1);
    rst = 1;
    #1;
    chk("rstack_drop", ld_ack, 0);
    chk("rstack_rdata", ld_rdata, 0);
    ld_req = 0;
    tick();
    rst = 0;
    #1;
`ifdef DM_ARB_STATS_EN
    chk("rstack_stall_cycles", stall_cycles, 0);
    chk("rstack_ld_grants", ld_grants, 0);
`endif

    // Contention again: starve_cnt must restart from 0
    cpu_req = 1; cpu_addr = 8'h10;
    ld_req = 1; ld_we = 0; ld_addr = 8'h30;
    #1;
    chk("strict_stall", z_stall, 1);
    chk("strict_addr", z_addr, 8'h30);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post_c%0d_stall", c), cpu_stall, 0);
      tick();
    end
    chk("post_c4_stall", cpu_stall, 1);
    chk("post_c4_addr", mem_addr, 8'h30);
    tick();
    chk("post_c5_ack", ld_ack, 1);
    chk("post_c5_rdata", ld_rdata, 8'h77);
    chk("post_c5_stall", cpu_stall, 0);
`ifdef DM_ARB_STATS_EN
    chk("post_stall_cycles", stall_cycles, 1);
    chk("post_ld_grants", ld_grants, 1);
`endif
    ld_req = 0; cpu_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
